// File: rtl/bus_host_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bus_host_arbiter
// Description : Multi-host to single-device bus arbiter. Allows at most one
//               transaction outstanding downstream. An IDLE/HOLD/RESP state
//               machine sequences arbitration, grant handshake and response
//               routing. Responses are passed straight through to the owning
//               host with zero latency.
//
// Configuration macro:
//   ARB_ROUND_ROBIN_EN  defined   -> round-robin arbitration. The search starts
//                                    at a priority pointer that advances past
//                                    the owner on every downstream grant.
//                       undefined -> fixed priority (lowest index wins), and
//                                    no pointer is implemented.
//
// Parameters:
//   NrHosts       number of requesting hosts (2..8)
//   DataWidth     data width in bits
//   AddressWidth  address width in bits
//
// Ports:
//   clk_i, rst_ni              clock; asynchronous active-low reset
//   host_req_i / host_gnt_o    per-host request / grant
//   host_addr_i, host_we_i,
//   host_be_i, host_wdata_i    per-host request payload
//   host_rvalid_o, host_rdata_o,
//   host_err_o                 per-host response
//   dev_req_o, dev_addr_o, dev_we_o,
//   dev_be_o, dev_wdata_o      downstream request
//   dev_gnt_i, dev_rvalid_i,
//   dev_rdata_i, dev_err_i     downstream grant and response
//
// Revision    : 1.0  initial release
// ============================================================================
module bus_host_arbiter #(
  parameter int unsigned NrHosts      = 2,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned AddressWidth = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,

  // Host side
  input  logic                      host_req_i    [NrHosts],
  output logic                      host_gnt_o    [NrHosts],
  input  logic [AddressWidth-1:0]   host_addr_i   [NrHosts],
  input  logic                      host_we_i     [NrHosts],
  input  logic [DataWidth/8-1:0]    host_be_i     [NrHosts],
  input  logic [DataWidth-1:0]      host_wdata_i  [NrHosts],
  output logic                      host_rvalid_o [NrHosts],
  output logic [DataWidth-1:0]      host_rdata_o  [NrHosts],
  output logic                      host_err_o    [NrHosts],

  // Device side
  output logic                      dev_req_o,
  output logic [AddressWidth-1:0]   dev_addr_o,
  output logic                      dev_we_o,
  output logic [DataWidth/8-1:0]    dev_be_o,
  output logic [DataWidth-1:0]      dev_wdata_o,
  input  logic                      dev_gnt_i,
  input  logic                      dev_rvalid_i,
  input  logic [DataWidth-1:0]      dev_rdata_i,
  input  logic                      dev_err_i
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int unsigned c_idx_w = (NrHosts > 1) ? $clog2(NrHosts) : 1;
  localparam logic [c_idx_w-1:0] c_last_host = c_idx_w'(NrHosts - 1);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_hold = 2'd1;
  localparam logic [1:0] c_st_resp = 2'd2;

  // --------------------------------------------------------------------------
  // Signals
  // --------------------------------------------------------------------------
  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [c_idx_w-1:0] r_owner;
  logic [c_idx_w-1:0] w_winner;
  logic [c_idx_w-1:0] w_sel;
  logic               w_any_req;
  logic               w_fire;
  logic               w_resp_done;

  // --------------------------------------------------------------------------
  // Request summary
  // --------------------------------------------------------------------------
  always_comb begin
    w_any_req = 1'b0;
    for (int i = 0; i < NrHosts; i++) begin
      w_any_req = w_any_req | host_req_i[i];
    end
  end

  // --------------------------------------------------------------------------
  // Winner selection
  // --------------------------------------------------------------------------
`ifdef ARB_ROUND_ROBIN_EN
  // The candidate index is one bit wider than a host index so that
  // pointer+offset can be wrapped back into range without overflow.
  localparam logic [c_idx_w:0] c_nr_hosts = (c_idx_w + 1)'(NrHosts);

  logic [c_idx_w-1:0] r_ptr;
  logic [c_idx_w:0]   w_cand;
  logic               w_found;

  always_comb begin
    w_winner = '0;
    w_found  = 1'b0;
    w_cand   = '0;
    for (int i = 0; i < NrHosts; i++) begin
      w_cand = {1'b0, r_ptr} + (c_idx_w + 1)'(i);
      if (w_cand >= c_nr_hosts) begin
        w_cand = w_cand - c_nr_hosts;
      end
      if (!w_found && host_req_i[w_cand[c_idx_w-1:0]]) begin
        w_winner = w_cand[c_idx_w-1:0];
        w_found  = 1'b1;
      end
    end
  end

  // The pointer moves only when the downstream grant is accepted, and then
  // moves to just past the host that was granted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ptr <= '0;
    end else if (w_fire) begin
      r_ptr <= (w_sel == c_last_host) ? '0 : w_sel + 1'b1;
    end
  end
`else
  // Fixed priority: scan from the top so that the lowest requesting
  // index is the last one written and therefore wins.
  always_comb begin
    w_winner = '0;
    for (int i = NrHosts - 1; i >= 0; i--) begin
      if (host_req_i[i]) begin
        w_winner = c_idx_w'(i);
      end
    end
  end
`endif

  // In HOLD the registered owner is frozen, so a later request from another
  // host (or the owner dropping its request) cannot change the payload.
  assign w_sel = (r_state == c_st_hold) ? r_owner : w_winner;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: begin
        if (w_any_req) begin
          w_state_nxt = dev_gnt_i ? c_st_resp : c_st_hold;
        end
      end
      c_st_hold: begin
        if (dev_gnt_i) begin
          w_state_nxt = c_st_resp;
        end
      end
      c_st_resp: begin
        // Requests seen in this cycle wait for IDLE, giving a minimum
        // issue interval of two cycles.
        if (dev_rvalid_i) begin
          w_state_nxt = c_st_idle;
        end
      end
      default: begin
        w_state_nxt = c_st_idle;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: output logic
  // --------------------------------------------------------------------------
  // Outputs are qualified with rst_ni so that they are quiet for the whole
  // reset window, even while hosts keep requesting.
  always_comb begin
    dev_req_o = 1'b0;
    case (r_state)
      c_st_idle: dev_req_o = w_any_req;
      c_st_hold: dev_req_o = 1'b1;
      default:   dev_req_o = 1'b0;
    endcase
    if (!rst_ni) begin
      dev_req_o = 1'b0;
    end
  end

  assign w_fire      = dev_req_o & dev_gnt_i;
  assign w_resp_done = rst_ni & (r_state == c_st_resp) & dev_rvalid_i;

  // --------------------------------------------------------------------------
  // Owner register
  // --------------------------------------------------------------------------
  // Captured on the arbitration cycle whether or not the grant arrives, so
  // both HOLD and RESP know which host the transaction belongs to.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_owner <= '0;
    end else if ((r_state == c_st_idle) && w_any_req) begin
      r_owner <= w_winner;
    end
  end

  // --------------------------------------------------------------------------
  // Downstream payload
  // --------------------------------------------------------------------------
  assign dev_addr_o  = host_addr_i[w_sel];
  assign dev_we_o    = host_we_i[w_sel];
  assign dev_be_o    = host_be_i[w_sel];
  assign dev_wdata_o = host_wdata_i[w_sel];

  // --------------------------------------------------------------------------
  // Per-host grant and response routing
  // --------------------------------------------------------------------------
  for (genvar g = 0; g < NrHosts; g++) begin : g_host
    assign host_gnt_o[g]    = w_fire && (w_sel == c_idx_w'(g));
    assign host_rvalid_o[g] = w_resp_done && (r_owner == c_idx_w'(g));
    assign host_err_o[g]    = host_rvalid_o[g] & dev_err_i;
    assign host_rdata_o[g]  = dev_rdata_i;
  end

endmodule
`default_nettype wire

// File: tb/tb_bus_host_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_host_arbiter
// Description : Directed self-checking bench for bus_host_arbiter with two
//               hosts. Inputs change 1 time unit after the rising edge and
//               outputs are checked 3 units later, well before the next edge.
//               Expected arbitration order follows ARB_ROUND_ROBIN_EN.
// Revision    : 1.0  initial release
// ============================================================================
module tb_bus_host_arbiter;

  localparam int N  = 2;
  localparam int DW = 32;
  localparam int AW = 32;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;

  logic          host_req    [N];
  logic          host_gnt    [N];
  logic [AW-1:0] host_addr   [N];
  logic          host_we     [N];
  logic [DW/8-1:0] host_be   [N];
  logic [DW-1:0] host_wdata  [N];
  logic          host_rvalid [N];
  logic [DW-1:0] host_rdata  [N];
  logic          host_err    [N];

  logic            dev_req;
  logic [AW-1:0]   dev_addr;
  logic            dev_we;
  logic [DW/8-1:0] dev_be;
  logic [DW-1:0]   dev_wdata;
  logic            dev_gnt;
  logic            dev_rvalid;
  logic [DW-1:0]   dev_rdata;
  logic            dev_err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bus_host_arbiter #(
    .NrHosts      (N),
    .DataWidth    (DW),
    .AddressWidth (AW)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .host_req_i    (host_req),
    .host_gnt_o    (host_gnt),
    .host_addr_i   (host_addr),
    .host_we_i     (host_we),
    .host_be_i     (host_be),
    .host_wdata_i  (host_wdata),
    .host_rvalid_o (host_rvalid),
    .host_rdata_o  (host_rdata),
    .host_err_o    (host_err),
    .dev_req_o     (dev_req),
    .dev_addr_o    (dev_addr),
    .dev_we_o      (dev_we),
    .dev_be_o      (dev_be),
    .dev_wdata_o   (dev_wdata),
    .dev_gnt_i     (dev_gnt),
    .dev_rvalid_i  (dev_rvalid),
    .dev_rdata_i   (dev_rdata),
    .dev_err_i     (dev_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic dev_quiet();
    dev_gnt    = 1'b0;
    dev_rvalid = 1'b0;
    dev_rdata  = '0;
    dev_err    = 1'b0;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    host_req[0] = 1'b0;
    host_req[1] = 1'b0;
    dev_quiet();
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
  endtask

  int exp_w;

  initial begin
    // Fixed per-host payloads, distinct in every field.
    host_addr[0]  = 32'h0010_0000;
    host_we[0]    = 1'b0;
    host_be[0]    = 4'hF;
    host_wdata[0] = 32'h1111_0000;
    host_addr[1]  = 32'h0020_0000;
    host_we[1]    = 1'b1;
    host_be[1]    = 4'h3;
    host_wdata[1] = 32'h2222_0000;

    // Reset state: outputs quiet although both hosts request.
    host_req[0] = 1'b1;
    host_req[1] = 1'b1;
    dev_quiet();
    dev_rvalid  = 1'b1;
    next_cycle();
    settle();
    check("rst_dev_req", dev_req, 0);
    check("rst_gnt0", host_gnt[0], 0);
    check("rst_gnt1", host_gnt[1], 0);
    check("rst_rvalid0", host_rvalid[0], 0);
    check("rst_rvalid1", host_rvalid[1], 0);
    check("rst_err0", host_err[0], 0);

    // Single host read.
    do_reset();
    host_req[0] = 1'b1;
    dev_gnt     = 1'b1;
    settle();
    check("single_dev_req", dev_req, 1);
    check("single_addr", dev_addr, 32'h0010_0000);
    check("single_we", dev_we, 0);
    check("single_gnt0", host_gnt[0], 1);
    check("single_gnt1", host_gnt[1], 0);
    next_cycle();
    host_req[0] = 1'b0;
    dev_gnt     = 1'b0;
    dev_rvalid  = 1'b1;
    dev_rdata   = 32'hDEAD_BEEF;
    settle();
    check("single_resp_dev_req", dev_req, 0);
    check("single_rvalid0", host_rvalid[0], 1);
    check("single_rdata0", host_rdata[0], 32'hDEAD_BEEF);
    check("single_rvalid1", host_rvalid[1], 0);
    check("single_err0", host_err[0], 0);
    next_cycle();

    // Spurious rvalid in IDLE.
    dev_rvalid = 1'b1;
    settle();
    check("spur_idle_rvalid0", host_rvalid[0], 0);
    check("spur_idle_rvalid1", host_rvalid[1], 0);
    next_cycle();
    dev_quiet();

    // Both hosts request continuously, gnt always 1, rvalid next cycle.
    do_reset();
    host_req[0] = 1'b1;
    host_req[1] = 1'b1;
    for (int k = 0; k < 4; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
      exp_w = k % 2;
`else
      exp_w = 0;
`endif
      dev_gnt    = 1'b1;
      dev_rvalid = 1'b0;
      settle();
      check($sformatf("both_gnt0_%0d", k), host_gnt[0], (exp_w == 0) ? 1 : 0);
      check($sformatf("both_gnt1_%0d", k), host_gnt[1], (exp_w == 1) ? 1 : 0);
      check($sformatf("both_addr_%0d", k), dev_addr, (exp_w == 1) ? 32'h0020_0000 : 32'h0010_0000);
      next_cycle();
      dev_rvalid = 1'b1;
      dev_rdata  = 32'hA000_0000 + k;
      settle();
      check($sformatf("both_gap_dev_req_%0d", k), dev_req, 0);
      check($sformatf("both_gap_gnt_%0d", k), {host_gnt[1], host_gnt[0]}, 0);
      check($sformatf("both_rvalid_%0d", k), {host_rvalid[1], host_rvalid[0]},
            (exp_w == 1) ? 2'b10 : 2'b01);
      next_cycle();
    end

    // Grant stalled 3 cycles; host1 joins, host0 drops mid-hold.
    do_reset();
    host_req[0] = 1'b1;
    dev_gnt     = 1'b0;
    settle();
    check("hold_c1_dev_req", dev_req, 1);
    check("hold_c1_addr", dev_addr, 32'h0010_0000);
    check("hold_c1_gnt0", host_gnt[0], 0);
    next_cycle();
    host_req[1] = 1'b1;
    dev_rvalid  = 1'b1;
    settle();
    check("hold_c2_addr", dev_addr, 32'h0010_0000);
    check("hold_c2_wdata", dev_wdata, 32'h1111_0000);
    check("hold_c2_gnt1", host_gnt[1], 0);
    check("hold_c2_rvalid", {host_rvalid[1], host_rvalid[0]}, 0);
    next_cycle();
    host_req[0] = 1'b0;
    dev_rvalid  = 1'b0;
    settle();
    check("hold_c3_dev_req", dev_req, 1);
    check("hold_c3_be", dev_be, 4'hF);
    check("hold_c3_addr", dev_addr, 32'h0010_0000);
    next_cycle();
    dev_gnt = 1'b1;
    settle();
    check("hold_c4_gnt0", host_gnt[0], 1);
    check("hold_c4_gnt1", host_gnt[1], 0);
    check("hold_c4_addr", dev_addr, 32'h0010_0000);
    next_cycle();
    dev_gnt    = 1'b0;
    dev_rvalid = 1'b1;
    dev_rdata  = 32'h0000_1234;
    settle();
    check("hold_resp_rvalid0", host_rvalid[0], 1);
    check("hold_resp_rvalid1", host_rvalid[1], 0);
    next_cycle();

    // Host1 transaction completing with an error.
    dev_rvalid = 1'b0;
    dev_gnt    = 1'b1;
    settle();
    check("err_gnt1", host_gnt[1], 1);
    check("err_addr", dev_addr, 32'h0020_0000);
    check("err_we", dev_we, 1);
    next_cycle();
    host_req[1] = 1'b0;
    dev_gnt     = 1'b0;
    dev_rvalid  = 1'b1;
    dev_err     = 1'b1;
    settle();
    check("err_rvalid1", host_rvalid[1], 1);
    check("err_err1", host_err[1], 1);
    check("err_err0", host_err[0], 0);
    check("err_rvalid0", host_rvalid[0], 0);
    next_cycle();
    dev_quiet();

    // Reset while in RESP abandons the transaction and clears the pointer.
    do_reset();
    host_req[0] = 1'b1;
    dev_gnt     = 1'b1;
    settle();
    check("rstresp_gnt0", host_gnt[0], 1);
    next_cycle();
    host_req[0] = 1'b0;
    dev_gnt     = 1'b0;
    rst_n       = 1'b0;
    settle();
    check("rstresp_dev_req", dev_req, 0);
    next_cycle();
    rst_n      = 1'b1;
    dev_rvalid = 1'b1;
    settle();
    check("rstresp_rvalid0", host_rvalid[0], 0);
    check("rstresp_rvalid1", host_rvalid[1], 0);
    next_cycle();
    dev_rvalid  = 1'b0;
    host_req[0] = 1'b1;
    host_req[1] = 1'b1;
    dev_gnt     = 1'b1;
    settle();
    check("rstresp_idle_dev_req", dev_req, 1);
    check("rstresp_ptr_gnt0", host_gnt[0], 1);
    check("rstresp_ptr_gnt1", host_gnt[1], 0);
    next_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
